// File: rtl/nr52_controller.sv
// NR52 master sound control: power bit, channel-active flags and the power-off
// register-file clear sequencer.
module nr52_controller #(
    parameter int unsigned NUM_REGS = 20,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              nr52_wr_en,
    input  logic [7:0]        nr52_wdata,
    input  logic [3:0]        trigger,
    input  logic [3:0]        length_expire,
    input  logic [3:0]        dac_off,
    output logic [7:0]        nr52_out,
    output logic              reg_wr_allow,
    output logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    input  logic              clr_ack
);

    typedef enum logic [1:0] {StOff, StOn, StClear} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    state_e            state_q;
    logic              power_q;
    logic [3:0]        ch_on_q;
    logic              pending_on_q;
    logic              clr_req_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              reg_wr_allow_q;

    logic       wr_on;
    logic       wr_off;
    logic       pending_eff;
    logic [3:0] ch_on_d;
    logic       unused_wdata;

    assign wr_on        = nr52_wr_en & nr52_wdata[7];
    assign wr_off       = nr52_wr_en & ~nr52_wdata[7];
    assign unused_wdata = ^nr52_wdata[6:0];

    // A write landing on the final ack still decides where the clear exits to.
    assign pending_eff = nr52_wr_en ? nr52_wdata[7] : pending_on_q;

    // dac_off beats trigger, trigger beats length expiry.
    always_comb begin
        ch_on_d = (ch_on_q | trigger) & ~dac_off & ~(length_expire & ~trigger);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= StOff;
            power_q        <= 1'b0;
            ch_on_q        <= 4'b0000;
            pending_on_q   <= 1'b0;
            clr_req_q      <= 1'b0;
            clr_addr_q     <= '0;
            reg_wr_allow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (wr_on) begin
                        state_q        <= StOn;
                        power_q        <= 1'b1;
                        reg_wr_allow_q <= 1'b1;
                    end
                end
                StOn: begin
                    if (wr_off) begin
                        state_q        <= StClear;
                        power_q        <= 1'b0;
                        ch_on_q        <= 4'b0000;
                        clr_req_q      <= 1'b1;
                        clr_addr_q     <= '0;
                        reg_wr_allow_q <= 1'b0;
                    end else begin
                        ch_on_q <= ch_on_d;
                    end
                end
                StClear: begin
                    if (nr52_wr_en) begin
                        pending_on_q <= nr52_wdata[7];
                    end
                    if (clr_ack) begin
                        if (clr_addr_q == LastAddr) begin
                            state_q        <= pending_eff ? StOn : StOff;
                            power_q        <= pending_eff;
                            reg_wr_allow_q <= pending_eff;
                            pending_on_q   <= 1'b0;
                            clr_req_q      <= 1'b0;
                            clr_addr_q     <= '0;
                        end else begin
                            clr_addr_q <= clr_addr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StOff;
                end
            endcase
        end
    end

    assign nr52_out     = {power_q, 3'b000, ch_on_q};
    assign reg_wr_allow = reg_wr_allow_q;
    assign clr_req      = clr_req_q;
    assign clr_addr     = clr_addr_q;

endmodule

// File: tb/tb_nr52_controller.sv
// Scoreboard bench for nr52_controller: the driver pushes model predictions,
// a monitor pops and compares them against the DUT every cycle.
module tb_nr52_controller;

    localparam int NUM_REGS = 20;
    localparam int ADDR_W   = 5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              nr52_wr_en = 1'b0;
    logic [7:0]        nr52_wdata = 8'h00;
    logic [3:0]        trigger = 4'h0;
    logic [3:0]        length_expire = 4'h0;
    logic [3:0]        dac_off = 4'h0;
    logic [7:0]        nr52_out;
    logic              reg_wr_allow;
    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_ack = 1'b0;

    nr52_controller #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .nr52_wr_en   (nr52_wr_en),
        .nr52_wdata   (nr52_wdata),
        .trigger      (trigger),
        .length_expire(length_expire),
        .dac_off      (dac_off),
        .nr52_out     (nr52_out),
        .reg_wr_allow (reg_wr_allow),
        .clr_req      (clr_req),
        .clr_addr     (clr_addr),
        .clr_ack      (clr_ack)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]        nr52;
        logic              allow;
        logic              req;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the pending clear is simply a list of indices still to zero.
    bit       m_power = 1'b0;
    bit [3:0] m_ch = 4'h0;
    bit       m_pend = 1'b0;
    int       m_clr[$];

    task automatic model_step(input bit rst, input bit wr, input logic [7:0] wd,
                              input logic [3:0] trg, input logic [3:0] le,
                              input logic [3:0] dac, input bit ack);
        exp_t e;
        if (!rst) begin
            m_power = 1'b0;
            m_ch    = 4'h0;
            m_pend  = 1'b0;
            m_clr.delete();
        end else if (m_clr.size() > 0) begin
            if (wr) m_pend = wd[7];
            if (ack) begin
                void'(m_clr.pop_front());
                if (m_clr.size() == 0) begin
                    m_power = m_pend;
                    m_pend  = 1'b0;
                end
            end
        end else if (m_power) begin
            if (wr && !wd[7]) begin
                m_power = 1'b0;
                m_ch    = 4'h0;
                for (int i = 0; i < NUM_REGS; i++) m_clr.push_back(i);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (dac[i])      m_ch[i] = 1'b0;
                    else if (trg[i]) m_ch[i] = 1'b1;
                    else if (le[i])  m_ch[i] = 1'b0;
                end
            end
        end else if (wr && wd[7]) begin
            m_power = 1'b1;
        end
        e.nr52  = {m_power, 3'b000, m_ch};
        e.allow = m_power;
        e.req   = (m_clr.size() > 0);
        e.addr  = (m_clr.size() > 0) ? ADDR_W'(m_clr[0]) : '0;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit wr, input logic [7:0] wd,
                       input logic [3:0] trg, input logic [3:0] le,
                       input logic [3:0] dac, input bit ack);
        @(negedge clock);
        reset_n       = rst;
        nr52_wr_en    = wr;
        nr52_wdata    = wd;
        trigger       = trg;
        length_expire = le;
        dac_off       = dac;
        clr_ack       = ack;
        model_step(rst, wr, wd, trg, le, dac, ack);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("nr52_out", nr52_out, e.nr52);
                check("reg_wr_allow", 8'(reg_wr_allow), 8'(e.allow));
                check("clr_req", 8'(clr_req), 8'(e.req));
                check("clr_addr", 8'(clr_addr), 8'(e.addr));
            end
        end
    end

    initial begin : driver
        logic [3:0] dac_lvl;
        cyc(0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 0);
        cyc(0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 1);
        // Power on, then channel flag rules.
        cyc(1, 1, 8'h80, 4'h0, 4'h0, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b0101, 4'h0, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b1010, 4'h0, 4'h0, 0);
        cyc(1, 1, 8'hFF, 4'h0, 4'b0010, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b0010, 4'h0, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'h0, 4'h0, 4'b1000, 0);
        cyc(1, 0, 8'h00, 4'b1000, 4'h0, 4'b1000, 0);
        cyc(1, 0, 8'h00, 4'b0001, 4'b0001, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b1000, 4'h0, 4'h0, 0);
        // Power-off coinciding with triggers, ack every cycle.
        cyc(1, 1, 8'h0F, 4'b1111, 4'h0, 4'h0, 1);
        for (int i = 0; i < NUM_REGS + 3; i++) cyc(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 1);
        // Power-off with ack every third cycle and pending writes mid-clear.
        cyc(1, 1, 8'h80, 4'h0, 4'h0, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b1111, 4'h0, 4'h0, 0);
        cyc(1, 1, 8'h00, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 3 * NUM_REGS + 6; i++) begin
            cyc(1, (i == 10) || (i == 20) || (i == 25),
                (i == 20) ? 8'h00 : 8'h80, 4'h0, 4'h0, 4'h0, (i % 3) == 2);
        end
        // Reset in the middle of a clear, then OFF-state no-ops.
        cyc(1, 1, 8'h00, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 1);
        cyc(0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 1);
        cyc(1, 0, 8'h00, 4'b1111, 4'h0, 4'h0, 0);
        cyc(1, 1, 8'h0F, 4'h0, 4'h0, 4'h0, 0);
        cyc(1, 0, 8'h00, 4'b1111, 4'h0, 4'h0, 1);
        // Random traffic.
        dac_lvl = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dac_lvl = 4'($urandom) & 4'($urandom);
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 9) == 0, 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                dac_lvl, $urandom_range(0, 1) == 1);
        end
        cyc(1, 0, 8'h00, 4'h0, 4'h0, 4'h0, 0);
        @(posedge clock);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
